fifo_reader: RTL
================

Name: fifo_reader

Overview:
- Read-side controller for the team's synchronous FIFO (push/pop/full/empty, registered DataOutput).
- Drives the FIFO pop strobe and captures the FIFO output word.
- Presents words downstream on a valid/ready stream through a 2-entry skid buffer, sustaining 1 word/cycle.
- Sits between the FIFO and any streaming consumer; an enable input starts and cleanly stops the flow.

Parameters:
DATA_WIDTH, 16, width of FIFO words and out_data
CNT_WIDTH, 16, width of word_count (only used when FIFO_READER_CNT_EN is defined)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = fetch words from the FIFO; 0 = stop fetching and drain
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO DataOutput; valid the cycle after a sampled pop
fifo_pop  output  1  pop strobe to FIFO, sampled on the rising clk edge
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts the word this cycle
out_data  output  DATA_WIDTH  head word of the skid buffer
busy  output  1  state != IDLE
word_count  output  CNT_WIDTH  only with FIFO_READER_CNT_EN

Behaviour:
- Reset (reset=0, asynchronous): fifo_pop=0, out_valid=0, out_data=0, busy=0, buffer empty, in-flight flag 0, state IDLE, word_count=0.
- FIFO read latency is exactly 1:
  - a pop sampled at edge N puts the word on fifo_data after edge N;
  - the word is captured into the skid buffer at edge N+1;
  - a 1-bit in-flight flag tracks the outstanding pop.
- Define occ = buffer entries (0..2), inflight = in-flight flag, deq = out_valid & out_ready.
- fifo_pop = (state==RUN) & !fifo_empty & (occ + inflight - deq < 2).
  - fifo_pop is combinational from out_ready, fifo_empty and state.
  - It is never asserted while fifo_empty=1.
  - This rule gives back-to-back pops every cycle when out_ready is held at 1.
- Skid buffer:
  - FIFO order.
  - out_data is always the oldest entry; out_valid = (occ>0).
  - Captured word and dequeue in the same cycle: occ is unchanged and the head advances.
  - occ never exceeds 2, and no word is dropped or duplicated.
- out_data/out_valid are stable while out_valid=1 and out_ready=0.
- FSM:
  - IDLE: fifo_pop=0. If enable=1, go to RUN on the next edge.
  - RUN: pops per the rule above. If enable=0, go to DRAIN on the next edge; fifo_pop is already forced 0 in the cycle enable is seen low.
  - DRAIN: no pops. The in-flight word is still captured. When occ=0 and inflight=0, go to IDLE.
  - DRAIN with enable=1 again: go back to RUN.
- FIFO empty while in RUN: stay in RUN with fifo_pop=0 and resume popping when fifo_empty falls. This is not an error.
- Reset mid-transfer: all state is cleared immediately, and any word in flight from the FIFO is discarded. The FIFO is reset together with this block.
- out_valid does not depend combinationally on out_ready. out_data is registered, with no combinational path from fifo_data.

Optional Feature:
- Macro FIFO_READER_CNT_EN.
- Defined:
  - adds the word_count output;
  - word_count increments by 1 on every edge where out_valid & out_ready;
  - it saturates at 2^CNT_WIDTH-1;
  - it is cleared only by reset.
- Not defined: the word_count port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Bench setup: 16-bit, 8-deep FIFO model with registered read, clk period 4.
- Reset/idle: reset=0 then release with enable=0 -> fifo_pop, out_valid, busy and word_count all stay 0 while the FIFO holds 4 words.
- Streaming: push 8,7,6,5,4,3,2,1, enable=1, out_ready=1 -> fifo_pop high 8 consecutive cycles; out_data 8..1 on 8 consecutive cycles, first word 2 edges after the first pop; word_count=8.
- Backpressure: with 8 words queued, hold out_ready=0 -> exactly 2 pops, then fifo_pop=0; out_data=8 stable. Toggle out_ready 1/0 -> order 8,7,6,..., no loss or duplication; occ never above 2.
- Empty/refill: FIFO runs empty mid-stream -> fifo_pop=0 while empty, state stays RUN. Push 1,3,5 -> words delivered in order 1,3,5.
- Stop/drain: drop enable with one pop in flight and occ=1 -> no further pops; both words delivered; busy falls when occ=0. Re-assert enable -> streaming resumes from the next FIFO word.
- Reset mid-stream: assert reset while out_valid=1 -> out_valid, out_data, fifo_pop and busy go to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fifo_reader.sv
// Read-side controller for the synchronous FIFO: pops words, lands them in a 2-entry skid buffer, streams them out on valid/ready.
// Optional macro FIFO_READER_CNT_EN adds a saturating word_count of delivered words.
module fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_count
`endif
);

  // Stream handshake: a word moves on every rising edge where out_valid & out_ready;
  // out_valid never depends on out_ready, and the word is held until taken.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic                  deq;
  logic [2:0]            pending;

  assign deq       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Words already owed to the buffer after this cycle's dequeue; a pop is safe only if room stays for it.
  assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_pop = (state == RUN) & enable & ~fifo_empty & (pending < 3'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                          state_nxt = RUN;
        else if (occ == 2'd0 && !inflight)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // buf0 is always the head; buf1 only ever holds the second word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_pop;
      case ({inflight, deq})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data;
          else             buf1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) buf0 <= buf1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          word_count <= '0;
    else if (deq && (word_count != '1))  word_count <= word_count + CNT_WIDTH'(1);
  end
`endif

endmodule
